// File: rtl/cnet_reg_arbiter_pkg.sv
// cnet_reg_arbiter_pkg: state encoding and constants shared by the CNET register arbiter.
package cnet_reg_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DROP, WAIT_RD, DONE} state_t;
  localparam logic RD = 1'b1;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/cnet_rr_arb2.sv
// cnet_rr_arb2: two-input round-robin arbiter with last-grant memory, one-hot grant when enabled.
module cnet_rr_arb2 (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic last_q;
  always_comb gnt_o = !en_i ? 2'b00 : (&req_i) ? (last_q ? 2'b01 : 2'b10) : req_i;
  always_ff @(posedge clk)
    if (!reset_L) last_q <= 1'b1;
    else if (|gnt_o) last_q <= gnt_o[1];
endmodule

// File: rtl/cnet_reg_arbiter.sv
// cnet_reg_arbiter: shares the CNET register port between two requesters, one transaction at a time.
// Define CNET_REG_ARB_TIMEOUT_EN to add a completion timeout that acks with err=1.
module cnet_reg_arbiter
  import cnet_reg_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 27,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [1:0]            req,
  input  logic [1:0]            rd_wr_L,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wr_data0,
  input  logic [DATA_WIDTH-1:0] wr_data1,
  output logic [1:0]            ack,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  cpci_req,
  output logic                  cpci_rd_wr_L,
  output logic [ADDR_WIDTH-1:0] cpci_addr,
  output logic [DATA_WIDTH-1:0] cpci_wr_data,
  output logic                  cpci_data_tri_en,
  input  logic [DATA_WIDTH-1:0] cpci_rd_data,
  input  logic                  cpci_wr_rdy,
  input  logic                  cpci_rd_rdy
);
  state_t                state_q;
  logic                  owner_q, drop_q, err_q, rd_wr_q, tri_q;
  logic                  sel, rdy, tmo, tmo_go;
  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  cnet_rr_arb2 u_arb (
    .clk    (clk),
    .reset_L(reset_L),
    .en_i   (state_q == IDLE),
    .req_i  (req),
    .gnt_o  (gnt)
  );
  assign sel              = gnt[1];
  assign rdy              = (rd_wr_q == RD) ? cpci_rd_rdy : cpci_wr_rdy;
  assign cpci_req         = (state_q == ISSUE) && rdy;
  assign ack              = (state_q == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign err              = err_q;
  assign rd_data          = rdata_q;
  assign cpci_rd_wr_L     = rd_wr_q;
  assign cpci_addr        = addr_q;
  assign cpci_wr_data     = wdata_q;
  assign cpci_data_tri_en = tri_q;
`ifdef CNET_REG_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk)
    if (!reset_L || state_q == IDLE) cnt_q <= '0;
    else if (state_q != DONE) cnt_q <= cnt_q + 1'b1;
  assign tmo = (state_q inside {ISSUE, WAIT_DROP, WAIT_RD}) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = (TIMEOUT_CYCLES < 0);
`endif
  // a real completion in the same cycle beats the timeout
  assign tmo_go = tmo && !(state_q == ISSUE && rdy) && !(state_q == WAIT_RD && cpci_rd_rdy);
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_wr_q <= 1'b1;
      tri_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|gnt) begin
          owner_q <= sel;
          rd_wr_q <= rd_wr_L[sel];
          tri_q   <= rd_wr_L[sel] != RD;
          addr_q  <= sel ? addr1 : addr0;
          wdata_q <= sel ? wr_data1 : wr_data0;
          drop_q  <= 1'b0;
          state_q <= ISSUE;
        end
        ISSUE: if (rdy) state_q <= (rd_wr_q == RD) ? WAIT_DROP : DONE;
        WAIT_DROP: begin
          drop_q <= ~drop_q;
          if (drop_q) state_q <= WAIT_RD;
        end
        WAIT_RD: if (cpci_rd_rdy) begin
          rdata_q <= cpci_rd_data;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
          tri_q   <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      if (tmo_go) begin
        state_q <= DONE;
        err_q   <= 1'b1;
        rdata_q <= DATA_WIDTH'(TIMEOUT_DATA);
      end
    end
  end
endmodule

// File: tb/tb_cnet_reg_arbiter.sv
// tb_cnet_reg_arbiter: scoreboard bench with a CNET responder model and round-robin reference model.
module tb_cnet_reg_arbiter;
  typedef struct packed {logic rw; logic [26:0] a; logic [31:0] d;} iss_t;
  typedef struct packed {logic o; logic rw; logic e; logic [31:0] rd;} ack_t;
  logic        clk = 1'b0, reset_L = 1'b0;
  logic [1:0]  req = 2'b00, rd_wr_L = 2'b00;
  logic [26:0] addr0 = '0, addr1 = '0;
  logic [31:0] wr_data0 = '0, wr_data1 = '0;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rd_data;
  logic        cpci_req, cpci_rd_wr_L, cpci_data_tri_en;
  logic [26:0] cpci_addr;
  logic [31:0] cpci_wr_data, cpci_rd_data;
  logic        cpci_wr_rdy = 1'b1, cpci_rd_rdy = 1'b1;
  iss_t iss_q[$];
  ack_t ack_q[$];
  int vec = 0, bad = 0, cyc = 0, iss_cnt = 0, ack_cnt = 0, iss_cyc = 0, ack_cyc = 0, prev_ack_cyc = 0;
  int prio = 0, rd_low_n = 0;
  bit rnd_mode = 1'b0, wr_block = 1'b0;

  cnet_reg_arbiter #(.ADDR_WIDTH(27), .DATA_WIDTH(32), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset_L(reset_L), .req(req), .rd_wr_L(rd_wr_L),
    .addr0(addr0), .addr1(addr1), .wr_data0(wr_data0), .wr_data1(wr_data1),
    .ack(ack), .err(err), .rd_data(rd_data),
    .cpci_req(cpci_req), .cpci_rd_wr_L(cpci_rd_wr_L), .cpci_addr(cpci_addr),
    .cpci_wr_data(cpci_wr_data), .cpci_data_tri_en(cpci_data_tri_en),
    .cpci_rd_data(cpci_rd_data), .cpci_wr_rdy(cpci_wr_rdy), .cpci_rd_rdy(cpci_rd_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rdfun(input logic [26:0] a);
    return (a == 27'h40) ? 32'hCAFE_F00D : ({a, 5'h0} ^ 32'h9E37_79B9);
  endfunction
  assign cpci_rd_data = rdfun(cpci_addr);

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  initial begin : cnet
    int rd_low;
    rd_low = 0;
    forever begin
      @(negedge clk);
      if (cpci_req && cpci_rd_wr_L) rd_low = rnd_mode ? int'($urandom_range(2, 6)) : rd_low_n;
      @(posedge clk);
      #1;
      if (!rnd_mode && rd_low > rd_low_n) rd_low = rd_low_n;
      cpci_rd_rdy = (rd_low == 0) && (!rnd_mode || $urandom_range(3) != 0);
      if (rd_low > 0) rd_low--;
      cpci_wr_rdy = !wr_block && (!rnd_mode || $urandom_range(3) != 0);
    end
  end

  initial begin : mon
    iss_t ie;
    ack_t ae;
    forever begin
      @(negedge clk);
      if (cpci_rd_wr_L && cpci_data_tri_en) chk("tri_en_on_read", 64'(1), 64'(0));
      if (cpci_req) begin
        iss_cnt++;
        iss_cyc = cyc;
        if (iss_q.size() == 0) chk("unexpected_issue", 64'(1), 64'(0));
        else begin
          ie = iss_q.pop_front();
          chk("bus_dir", 64'(cpci_rd_wr_L), 64'(ie.rw));
          chk("bus_addr", 64'(cpci_addr), 64'(ie.a));
          chk("bus_wdata", 64'(cpci_wr_data), 64'(ie.d));
          chk("bus_tri_en", 64'(cpci_data_tri_en), 64'(!ie.rw));
        end
      end
      if (ack != 2'b00) begin
        ack_cnt++;
        prev_ack_cyc = ack_cyc;
        ack_cyc = cyc;
        if (ack_q.size() == 0) chk("unexpected_ack", 64'(ack), 64'(0));
        else begin
          ae = ack_q.pop_front();
          chk("ack_owner", 64'(ack), ae.o ? 64'(2) : 64'(1));
          chk("ack_err", 64'(err), 64'(ae.e));
          if (ae.rw) chk("rd_data", 64'(rd_data), 64'(ae.rd));
        end
      end
    end
  end

  task automatic run_round(input logic [1:0] m, input logic [1:0] rw, input logic [26:0] a0, input logic [26:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1, input bit te, input int budget, output int st);
    int ord[$];
    int n;
    @(negedge clk);
    rd_wr_L = rw; addr0 = a0; addr1 = a1; wr_data0 = d0; wr_data1 = d1; req = m;
    st = cyc;
    if (m == 2'b11) ord = '{prio, 1 - prio};
    else ord = '{int'(m[1])};
    foreach (ord[i]) begin
      iss_q.push_back('{rw[ord[i]], (ord[i] != 0) ? a1 : a0, (ord[i] != 0) ? d1 : d0});
      ack_q.push_back('{ord[i] != 0, rw[ord[i]] || te, te, te ? 32'hDEAD_BEEF : rdfun((ord[i] != 0) ? a1 : a0)});
    end
    prio = 1 - ord[ord.size() - 1];
    n = 0;
    while (req != 2'b00 && n < budget) begin
      @(negedge clk);
      n++;
      req = req & ~ack;
    end
    chk("round_complete", 64'(req), 64'(0));
    req = 2'b00;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "ack"}, 64'(ack), 64'(0));
    chk({p, "err"}, 64'(err), 64'(0));
    chk({p, "rd_data"}, 64'(rd_data), 64'(0));
    chk({p, "cpci_req"}, 64'(cpci_req), 64'(0));
    chk({p, "rd_wr_L"}, 64'(cpci_rd_wr_L), 64'(1));
    chk({p, "addr"}, 64'(cpci_addr), 64'(0));
    chk({p, "wdata"}, 64'(cpci_wr_data), 64'(0));
    chk({p, "tri_en"}, 64'(cpci_data_tri_en), 64'(0));
  endtask

  initial begin : stim
    int st, base;
    repeat (3) @(negedge clk);
    chk_reset("rst_");
    reset_L = 1'b1;
    run_round(2'b01, 2'b00, 27'h10, 27'h0, 32'h1234_5678, 32'h0, 1'b0, 20, st);
    chk("wr_issue_lat", 64'(iss_cyc - st), 64'(1));
    chk("wr_ack_lat", 64'(ack_cyc - st), 64'(2));
    rd_low_n = 5;
    run_round(2'b10, 2'b10, 27'h0, 27'h40, 32'h0, 32'h55AA, 1'b0, 40, st);
    chk("rd_issue_lat", 64'(iss_cyc - st), 64'(1));
    chk("rd_ack_after_rdy", 64'(ack_cyc - iss_cyc), 64'(7));
    rd_low_n = 0;
    for (int i = 0; i < 4; i++) begin
      run_round(2'b11, 2'b00, 27'($urandom), 27'($urandom), $urandom, $urandom, 1'b0, 40, st);
      chk("b2b_spacing", 64'(ack_cyc - prev_ack_cyc), 64'(3));
    end
    wr_block = 1'b1;
    base = iss_cnt;
    fork
      begin
        repeat (10) @(negedge clk);
        chk("stall_no_issue", 64'(iss_cnt - base), 64'(0));
        wr_block = 1'b0;
      end
      run_round(2'b01, 2'b00, 27'h55, 27'h0, 32'hA5A5_0001, 32'h0, 1'b0, 40, st);
    join
    chk("stall_issue_lat", 64'(iss_cyc - st), 64'(10));
    chk("stall_ack_lat", 64'(ack_cyc - st), 64'(11));
`ifdef CNET_REG_ARB_TIMEOUT_EN
    rd_low_n = 1000;
    run_round(2'b01, 2'b01, 27'h77, 27'h0, 32'h0, 32'h0, 1'b1, 40, st);
    chk("timeout_within_21", 64'((ack_cyc - st) <= 21), 64'(1));
    rd_low_n = 0;
    repeat (2) @(negedge clk);
`endif
    rd_low_n = 1000;
    @(negedge clk);
    rd_wr_L = 2'b01; addr0 = 27'h123; wr_data0 = 32'h0BAD_F00D; req = 2'b01;
    st = cyc;
    base = ack_cnt;
    iss_q.push_back('{1'b1, 27'h123, 32'h0BAD_F00D});
    prio = 1;
    repeat (8) @(negedge clk);
`ifndef CNET_REG_ARB_TIMEOUT_EN
    repeat (32) @(negedge clk);
`endif
    chk("stuck_issue_lat", 64'(iss_cyc - st), 64'(1));
    chk("no_ack_while_stuck", 64'(ack_cnt - base), 64'(0));
    reset_L = 1'b0;
    req = 2'b00;
    @(negedge clk);
    chk_reset("mid_rst_");
    reset_L = 1'b1;
    prio = 0;
    rd_low_n = 0;
    run_round(2'b11, 2'b00, 27'h200, 27'h300, 32'h1111_0000, 32'h2222_0000, 1'b0, 40, st);
    chk("post_rst_no_extra_ack", 64'(ack_cnt - base), 64'(2));
    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++)
      run_round(2'($urandom_range(1, 3)), 2'($urandom), 27'($urandom), 27'($urandom), $urandom, $urandom, 1'b0, 200, st);
    rnd_mode = 1'b0;
    repeat (4) @(negedge clk);
    chk("iss_q_drained", 64'(iss_q.size()), 64'(0));
    chk("ack_q_drained", 64'(ack_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
